// File: rtl/mem_io_responder.sv
// Byte-wide CPU bus responder: 2^ADDR_WIDTH byte RAM, rx/tx byte streams, halt sequencing.
// Optional macro IO_CYCLE_COUNTER_EN adds the 32-bit cycle counter read at 0x30004..0x30007.
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        stop_out,
    output logic [1:0]  stateDbg
);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W = $clog2(TX_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} stateT;

    stateT                  state, stateNext;
    logic [7:0]             ram [2**ADDR_WIDTH];
    logic [7:0]             ramQ;
    logic                   rdIsRam;
    logic [7:0]             ioData, ioRdData;
    logic [7:0]             txMem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr, rdPtr;
    logic [CNT_W-1:0]       txCount;
    logic                   ioSel, rxRead, haltWrite, pushReq;
    logic                   txFull, txPop, txPush, rxStall, txStall;
    logic [2:0]             ioAddr;
    logic [ADDR_WIDTH-1:0]  ramIdx;
    logic                   unusedAddrBits;

    assign unusedAddrBits = ^cpu_a[31:18];

    assign ioSel     = (cpu_a[17:16] == 2'b11);
    assign ioAddr    = cpu_a[2:0];
    assign ramIdx    = cpu_a[ADDR_WIDTH-1:0];
    assign rxRead    = ioSel && !cpu_wr && (ioAddr == 3'd0);
    assign haltWrite = ioSel && cpu_wr && (ioAddr == 3'd4);
    // 0x00 on the data port is swallowed, except the halt marker written via 0x30004.
    assign pushReq   = haltWrite || (ioSel && cpu_wr && (ioAddr == 3'd0) && (cpu_dout != 8'h00));

    // Handshakes: a byte moves on rx when rx_valid && rx_ready, on tx when tx_valid && tx_ready,
    // at the same posedge; valid never waits on ready, and ready is only ever a one-cycle accept.
    assign tx_valid = !rst_in && (txCount != '0);
    assign tx_data  = txMem[rdPtr];
    assign txPop    = tx_valid && tx_ready;
    assign txFull   = (txCount == CNT_W'(TX_FIFO_DEPTH));
    assign rxStall  = rxRead && !rx_valid;
    assign txStall  = pushReq && txFull && !txPop;
    assign cpu_rdy  = !rst_in && (state == RUN) && !rxStall && !txStall;
    assign txPush   = cpu_rdy && pushReq;
    assign rx_ready = cpu_rdy && rxRead;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            txCount <= '0;
        end else begin
            if (txPush) begin
                txMem[wrPtr] <= haltWrite ? 8'h00 : cpu_dout;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
            if (txPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({txPush, txPop})
                2'b10:   txCount <= txCount + CNT_W'(1);
                2'b01:   txCount <= txCount - CNT_W'(1);
                default: txCount <= txCount;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (cpu_rdy && !ioSel) begin
            if (cpu_wr) begin
                ram[ramIdx] <= cpu_dout;
            end else begin
                ramQ <= ram[ramIdx];
            end
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] counter, snapshot;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            counter  <= '0;
            snapshot <= '0;
        end else begin
            counter <= counter + 32'd1;
            if (cpu_rdy && ioSel && !cpu_wr && (ioAddr == 3'd4)) begin
                snapshot <= counter;
            end
        end
    end
`endif

    always_comb begin
        ioRdData = 8'h00;
        if (ioAddr == 3'd0) begin
            ioRdData = rx_data;
        end
`ifdef IO_CYCLE_COUNTER_EN
        // Byte 0 is live so the snapshot it loads matches what the CPU just saw.
        else if (ioAddr[2]) begin
            ioRdData = (ioAddr[1:0] == 2'd0) ? counter[7:0] : snapshot[{ioAddr[1:0], 3'b000} +: 8];
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdIsRam <= 1'b0;
            ioData  <= 8'h00;
        end else if (cpu_rdy) begin
            rdIsRam <= !ioSel && !cpu_wr;
            ioData  <= (ioSel && !cpu_wr) ? ioRdData : 8'h00;
        end
    end

    assign cpu_din = rst_in ? 8'h00 : (rdIsRam ? ramQ : ioData);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (txPush && haltWrite) stateNext = DRAIN;
            DRAIN:   if (txCount == '0) stateNext = HALT;
            HALT:    stateNext = HALT;
            default: stateNext = RUN;
        endcase
    end

    assign stop_out = !rst_in && (state == HALT);
    assign stateDbg = state;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: queue/array model checked every cycle plus directed literal checks.
module tb_mem_io_responder;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] IDLE_A = 32'h0003_0001;
    localparam int          M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cpu_a = IDLE_A;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        stop_out;
    logic [1:0]  state_dbg;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rx_pulses = 0;
    int          mode = M_RUN;
    logic [7:0]  exp_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  ram_m [int];
    logic        pend = 1'b0;
    logic [7:0]  pend_exp = 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cnt = 32'd0;
    logic [31:0] snap = 32'd0;
`endif

    mem_io_responder #(.ADDR_WIDTH(17), .TX_FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .stop_out(stop_out), .stateDbg(state_dbg)
    );

    always #5 clk_in = ~clk_in;

    function automatic void chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: advances once per cycle at the negedge, from the bus rules alone.
    task automatic compare_loop();
        logic io, is_push, pop, exp_rdy, drained;
        logic [2:0] ia;
        logic [31:0] sh;
        forever begin
            @(negedge clk_in);
            if (rx_ready) rx_pulses++;
            if (rst_in) begin
                chk_b("rst_cpu_rdy", cpu_rdy, 1'b0);
                chk_b("rst_rx_ready", rx_ready, 1'b0);
                chk_b("rst_tx_valid", tx_valid, 1'b0);
                chk_b("rst_stop_out", stop_out, 1'b0);
                chk_v("rst_cpu_din", 32'(cpu_din), 32'h0);
                exp_q.delete();
                mode = M_RUN;
                pend = 1'b0;
`ifdef IO_CYCLE_COUNTER_EN
                cnt  = 32'd0;
                snap = 32'd0;
`endif
            end else begin
                if (pend) chk_v("model_cpu_din", 32'(cpu_din), 32'(pend_exp));
                pend = 1'b0;
                chk_b("model_stop_out", stop_out, mode == M_HALT);
                chk_b("model_tx_valid", tx_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) chk_v("model_tx_data", 32'(tx_data), 32'(exp_q[0]));
                io = (cpu_a[17:16] == 2'b11);
                ia = cpu_a[2:0];
                pop = (exp_q.size() != 0) && tx_ready;
                is_push = io && cpu_wr && ((ia == 3'd0 && cpu_dout != 8'h00) || ia == 3'd4);
                exp_rdy = (mode == M_RUN) && !(io && !cpu_wr && ia == 3'd0 && !rx_valid)
                          && !(is_push && exp_q.size() == DEPTH && !pop);
                chk_b("model_cpu_rdy", cpu_rdy, exp_rdy);
                chk_b("model_rx_ready", rx_ready, exp_rdy && io && !cpu_wr && ia == 3'd0);
                drained = (mode == M_DRAIN) && (exp_q.size() == 0);
                if (tx_valid && tx_ready) tx_log.push_back(tx_data);
                if (pop) void'(exp_q.pop_front());
                if (exp_rdy) begin
                    if (!io) begin
                        if (cpu_wr) begin
                            ram_m[int'(cpu_a[16:0])] = cpu_dout;
                        end else if (ram_m.exists(int'(cpu_a[16:0]))) begin
                            pend = 1'b1;
                            pend_exp = ram_m[int'(cpu_a[16:0])];
                        end
                    end else if (cpu_wr) begin
                        if (is_push) exp_q.push_back(ia == 3'd4 ? 8'h00 : cpu_dout);
                        if (ia == 3'd4) mode = M_DRAIN;
                    end else begin
                        pend = 1'b1;
                        pend_exp = 8'h00;
                        if (ia == 3'd0) pend_exp = rx_data;
`ifdef IO_CYCLE_COUNTER_EN
                        if (ia == 3'd4) begin
                            pend_exp = cnt[7:0];
                            snap = cnt;
                        end else if (ia[2]) begin
                            sh = snap >> (8 * int'(ia[1:0]));
                            pend_exp = sh[7:0];
                        end
`endif
                    end
                end
                if (drained) mode = M_HALT;
`ifdef IO_CYCLE_COUNTER_EN
                cnt = cnt + 32'd1;
`endif
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        cpu_a = IDLE_A; cpu_wr = 1'b0; cpu_dout = 8'h00;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [7:0] d, output int stalls);
        bit done;
        cpu_a = a; cpu_wr = w; cpu_dout = d;
        stalls = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk_in);
            if (cpu_rdy) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls >= 60) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL access_timeout: addr 0x%08h stalled %0d cycles, required acceptance", a, stalls);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk_in);
        #1;
        cpu_a = IDLE_A; cpu_wr = 1'b0; cpu_dout = 8'h00;
    endtask

    task automatic read_byte(input logic [31:0] a, output logic [7:0] v, output int stalls);
        access(a, 1'b0, 8'h00, stalls);
        @(negedge clk_in);
        v = cpu_din;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int st;
        logic [7:0] v;
        logic [31:0] val;
        logic [7:0] halt_exp [4];
        halt_exp = '{8'h51, 8'h52, 8'h53, 8'h00};
        fork
            compare_loop();
        join_none

        do_reset();

        // RAM write/read, address aliasing and ignored upper address bits
        access(32'h0000_0010, 1'b1, 8'hA5, st);
        chk_v("ram_wr_stall", 32'(st), 32'd0);
        read_byte(32'h0000_0010, v, st);
        chk_v("ram_rd_stall", 32'(st), 32'd0);
        chk_v("ram_rd_a5", 32'(v), 32'hA5);
        access(32'h0001_FFFF, 1'b1, 8'h3C, st);
        access(32'h0002_FFFF, 1'b1, 8'h5A, st);
        read_byte(32'h0001_FFFF, v, st);
        chk_v("ram_top_byte", 32'(v), 32'h3C);
        read_byte(32'h0000_FFFF, v, st);
        chk_v("ram_alias_bit17", 32'(v), 32'h5A);
        read_byte(32'hFFFC_0010, v, st);
        chk_v("ram_upper_bits_ignored", 32'(v), 32'hA5);

        // rx read stalls until rx_valid, single rx_ready pulse
        rx_pulses = 0;
        fork
            access(32'h0003_0000, 1'b0, 8'h00, st);
            begin
                repeat (5) @(posedge clk_in);
                #1;
                rx_data = 8'h41; rx_valid = 1'b1;
                @(posedge clk_in);
                #1;
                rx_valid = 1'b0; rx_data = 8'h00;
            end
        join
        @(negedge clk_in);
        chk_v("rx_din", 32'(cpu_din), 32'h41);
        @(posedge clk_in);
        #1;
        chk_v("rx_stall_cycles", 32'(st), 32'd5);
        chk_v("rx_ready_pulses", 32'(rx_pulses), 32'd1);

        // tx FIFO fill to full, stall on the ninth push, ordered drain
        tx_log.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            access(32'h0003_0000, 1'b1, 8'(8'h31 + i), st);
            chk_v("tx_fill_stall", 32'(st), 32'd0);
        end
        fork
            access(32'h0003_0000, 1'b1, 8'h39, st);
            begin
                repeat (3) @(posedge clk_in);
                #1;
                tx_ready = 1'b1;
            end
        join
        chk_v("tx_full_stall", 32'(st), 32'd3);
        for (int i = 0; i < 40 && tx_log.size() < 9; i++) @(posedge clk_in);
        #1;
        chk_v("tx_count", 32'(tx_log.size()), 32'd9);
        for (int i = 0; i < tx_log.size() && i < 9; i++) chk_v("tx_order", 32'(tx_log[i]), 32'h31 + 32'(i));
        access(32'h0003_0000, 1'b1, 8'h00, st);
        access(32'h0003_0001, 1'b1, 8'h55, st);
        repeat (5) @(posedge clk_in);
        #1;
        chk_v("tx_zero_ignored", 32'(tx_log.size()), 32'd9);
        @(negedge clk_in);
        chk_b("tx_idle_after_zero", tx_valid, 1'b0);
        @(posedge clk_in);
        #1;
        tx_ready = 1'b0;

        // coherent 32-bit counter read 100 cycles after reset
        do_reset();
        repeat (100) @(posedge clk_in);
        #1;
        val = 32'h0;
        for (int k = 0; k < 4; k++) begin
            read_byte(32'h0003_0004 + 32'(k), v, st);
            val = val | (32'(v) << (8 * k));
        end
`ifdef IO_CYCLE_COUNTER_EN
        chk_v("counter_snapshot", val, 32'd100);
`else
        chk_v("counter_absent", val, 32'd0);
`endif

        // halt: queued bytes drain, then the 0x00 marker, then stop_out
        tx_log.delete();
        tx_ready = 1'b0;
        access(32'h0003_0000, 1'b1, 8'h51, st);
        access(32'h0003_0000, 1'b1, 8'h52, st);
        access(32'h0003_0000, 1'b1, 8'h53, st);
        access(32'h0003_0004, 1'b1, 8'h77, st);
        @(negedge clk_in);
        chk_v("drain_state", 32'(state_dbg), 32'd1);
        chk_b("drain_rdy", cpu_rdy, 1'b0);
        chk_b("drain_tx_valid", tx_valid, 1'b1);
        @(posedge clk_in);
        #1;
        tx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (stop_out) break;
        end
        chk_b("halt_reached", stop_out, 1'b1);
        chk_v("halt_tx_count", 32'(tx_log.size()), 32'd4);
        for (int i = 0; i < tx_log.size() && i < 4; i++) chk_v("halt_tx_order", 32'(tx_log[i]), 32'(halt_exp[i]));
        repeat (5) @(negedge clk_in);
        chk_b("halt_held", stop_out, 1'b1);
        chk_b("halt_rdy", cpu_rdy, 1'b0);
        chk_v("halt_state", 32'(state_dbg), 32'd2);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_b("rst_clears_stop", stop_out, 1'b0);
        chk_b("rst_restores_rdy", cpu_rdy, 1'b1);
        @(posedge clk_in);
        #1;
        tx_ready = 1'b0;

        // reset while the FIFO holds 4 bytes and the CPU is stalled on an rx read
        for (int i = 0; i < 4; i++) access(32'h0003_0000, 1'b1, 8'(8'h61 + i), st);
        cpu_a = 32'h0003_0000; cpu_wr = 1'b0; rx_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_b("pre_rst_rx_stall", cpu_rdy, 1'b0);
        chk_b("pre_rst_tx_valid", tx_valid, 1'b1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        cpu_a = 32'h0003_0004;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_b("post_rst_tx_valid", tx_valid, 1'b0);
        chk_b("post_rst_rx_ready", rx_ready, 1'b0);
        chk_b("post_rst_rdy", cpu_rdy, 1'b1);
        @(posedge clk_in);
        #1;
        cpu_a = IDLE_A;
        @(negedge clk_in);
        chk_v("post_rst_counter", 32'(cpu_din), 32'h0);
        @(posedge clk_in);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus; the CPU is the initiator.
- Holds the 128 KB byte RAM and the memory-mapped I/O at 0x30000/0x30004.
- Returns read data one cycle after the address, drives the CPU ready/pause line, and connects to UART-side rx/tx byte streams.
- Sits in the top-level system between the cpu instance and the UART.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (RAM size 2^ADDR_WIDTH bytes)
TX_FIFO_DEPTH, 8, output byte FIFO entries (power of two, >=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
cpu_a  input  32  CPU address; only bits [17:0] are decoded
cpu_dout  input  8  CPU write data
cpu_wr  input  1  1 = write, 0 = read
cpu_din  output  8  read data to CPU, valid the cycle after the address
cpu_rdy  output  1  CPU ready; low pauses the CPU
rx_data  input  8  input byte from UART
rx_valid  input  1  rx_data available
rx_ready  output  1  one-cycle pop of rx_data
tx_data  output  8  output byte to UART
tx_valid  output  1  tx FIFO non-empty
tx_ready  input  1  UART accepts tx_data this cycle
stop_out  output  1  program halted, level

Behaviour:
- Clocking and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values:
  - cpu_din=0x00, rx_ready=0, tx_valid=0, stop_out=0, cpu_rdy=0 while rst_in=1.
  - tx FIFO empty, counter=0, counter snapshot=0, state=RUN.
  - RAM contents are not reset.
- Decode:
  - io_sel = (cpu_a[17:16]==2'b11).
  - RAM index = cpu_a[ADDR_WIDTH-1:0].
  - I/O address = cpu_a[2:0].
- A request is accepted on a posedge only when cpu_rdy=1. When cpu_rdy=0 the bus is held by the CPU and no side effect occurs.
- RAM write: the byte is stored at the accepting posedge. It is visible to a read of the same address at the next cycle.
- RAM read: cpu_din at cycle N+1 = RAM[addr presented at cycle N]. Fixed latency of 1.
- IO 0x30000 read:
  - rx_valid=1: accepted. rx_ready=1 for exactly that cycle. cpu_din next cycle = rx_data.
  - rx_valid=0: cpu_rdy=0 (combinational) until rx_valid rises.
- IO 0x30000 write:
  - cpu_dout==0x00 is ignored.
  - Otherwise the byte is pushed into the tx FIFO.
  - FIFO full: cpu_rdy=0 until a slot frees. A pop and a push in the same cycle while full is allowed (cpu_rdy=1).
- IO 0x30004..0x30007 read:
  - byte k=cpu_a[1:0] returns snapshot[8k+7:8k].
  - A read of 0x30004 returns the live counter[7:0] and loads snapshot = live counter.
  - Bytes 1..3 return the snapshot, giving a coherent 32-bit value.
- Cycle counter: 32-bit. Increments every clock when not in reset, regardless of cpu_rdy. Wraps 0xFFFFFFFF->0.
- Other I/O addresses: reads return 0x00, writes are ignored.
- tx FIFO: tx_data = head entry. Pop when tx_valid && tx_ready. Strict FIFO order.
- State machine:
  - RUN: normal operation. A write to 0x30004 pushes 0x00 into the tx FIFO (exempt from the ignore rule; stalls if full like any push). When that push is accepted, go to DRAIN.
  - DRAIN: cpu_rdy=0. Go to HALT when the FIFO is empty.
  - HALT: cpu_rdy=0, stop_out=1. Only rst_in exits.
- cpu_rdy = !rst_in && state==RUN && !rx_stall && !tx_stall.
- Reset mid-operation: FIFO contents are discarded, any pending stall clears, state returns to RUN at the next cycle.

Optional Feature:
IO_CYCLE_COUNTER_EN
- Defined: counter and snapshot present; 0x30004..0x30007 reads behave as above.
- Undefined: counter and snapshot are removed; those reads return 0x00. Write-to-0x30004 halt behaviour is unchanged.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> cpu_din=0xA5 exactly one cycle after the read address; cpu_rdy stays 1.
- Read 0x30000 with rx_valid=0 for 5 cycles, then rx_data=0x41, rx_valid=1 -> cpu_rdy=0 for 5 cycles; single rx_ready pulse; cpu_din=0x41 next cycle.
- tx_ready=0, write 0x31..0x39 (9 bytes) to 0x30000 with TX_FIFO_DEPTH=8 -> cpu_rdy drops on the 9th write. Raise tx_ready -> bytes emerge 0x31..0x39 in order. A write of 0x00 produces no tx byte.
- After 100 cycles post-reset, read 0x30004..0x30007 -> 32-bit value equals the counter at the 0x30004 read (±0); with macro undefined, all four bytes read 0x00.
- Queue 3 bytes with tx_ready=0, then write 0x30004 -> state DRAIN, cpu_rdy=0. Release tx_ready -> 3 bytes then 0x00 sent, then stop_out=1 held. Assert rst_in -> stop_out=0 and cpu_rdy=1 next cycle.
- Assert rst_in while the FIFO holds 4 bytes and the CPU is stalled on a 0x30000 read -> tx_valid=0, rx_ready=0, counter=0 after reset.
